alu32_seq_ctrl: RTL
===================

// Module: alu32_seq_ctrl
// PURPOSE
//  Sequences one 8-bit 74181-style ALU slice (S,A,B,M,CN -> F,CO; combinational) over 4 beats.
//  Result: full 32-bit arithmetic/logic op, with carry/borrow chained byte to byte, LSB first.
//  Sits between the MIPS datapath and the shared ALU slice; REQ/DONE handshake toward the datapath.
// PARAMETERS
//  NBEATS   4   slices per operation; result width = 8*NBEATS (only 4 verified)
// PORTS
//  CLK      in   1    single clock, all state on rising edge
//  RST_N    in   1    synchronous, active-low reset
//  REQ      in   1    start request; sampled only when BUSY=0
//  OP       in   4    ALU function select (S encoding), latched on accept
//  MODE     in   1    ALU M: 0=arithmetic, 1=logic; latched on accept
//  CIN      in   1    CN for beat 0 (carry-in for add, borrow-in for sub); latched
//  OPA      in   32   operand A, latched on accept
//  OPB      in   32   operand B, latched on accept
//  BUSY     out  1    1 from accept cycle+1 through last beat
//  DONE     out  1    one-cycle pulse: RES/COUT/ZERO valid
//  RES      out  32   result; held until next accept
//  COUT     out  1    CO of beat 3 when MODE=0; forced 0 when MODE=1
//  ZERO     out  1    RES==0, registered with DONE
//  ALU_S    out  4    to slice S
//  ALU_M    out  1    to slice M
//  ALU_CN   out  1    to slice CN
//  ALU_A    out  8    to slice A (current byte)
//  ALU_B    out  8    to slice B (current byte)
//  ALU_F    in   8    from slice F
//  ALU_CO   in   1    from slice CO (carry-out / borrow-out)
// BEHAVIOUR
//  Reset (RST_N=0 at edge): state IDLE; BUSY, DONE, RES, COUT, ZERO, all ALU_* = 0.
//  FSM: IDLE -> RUN (beats 0..NBEATS-1, beat counter) -> FIN -> IDLE.
//  Accept: REQ=1 in IDLE or FIN. Latches OP, MODE, CIN, OPA, OPB. Next state RUN, beat 0.
//  REQ in RUN is ignored, not queued. Requester holds REQ until it sees BUSY.
//  RUN beat k: ALU_A=OPA[8k+7:8k], ALU_B=OPB[8k+7:8k], both from operand shift regs.
//  RUN beat k (cont.): ALU_S=OP, ALU_M=MODE.
//  ALU_CN = CIN at beat 0. At beat k>0 it is the captured ALU_CO of beat k-1.
//  Chained carry on ALU_CN applies when MODE=0 only; ALU_CN=CIN on every beat when MODE=1.
//  End of beat k: RES[8k+7:8k] <= ALU_F; carry reg <= ALU_CO.
//  Add (S=1001) chains carry; sub (S=0110) chains borrow; CO=1 means borrow.
//  Latency: accept at edge n; beats at cycles n+1..n+4; DONE=1, BUSY=0 in cycle n+5 (FIN).
//  FIN: COUT, ZERO valid with DONE. Accept in FIN gives back-to-back ops with no idle cycle.
//  ALU_* outputs are 0 in IDLE and FIN (slice quiescent).
//  RES is updated byte-wise in RUN; consumers sample it only on DONE.
//  Reset mid-operation: abort, no DONE, all outputs 0 the next cycle.
//  Width: every byte op is 9-bit inside the slice; bit 8 of the last beat becomes COUT.
//  All wrap-around is mod 2^32.
// STRUCTURE
//  Package alu_seq_pkg: FSM state enum {IDLE,RUN,FIN}, SLICE_W=8, OP_ADD=4'b1001, OP_SUB=4'b0110.
//  Sub-module alu_seq_shreg: 32-bit load/shift-right-by-8 register, instantiated for OPA and OPB.
//  The ALU slice is instantiated at the top level, not inside this block.
// TESTING (bench instantiates the real 8-bit slice)
//  ADD M=0 CIN=0 A=0x000000FF B=0x00000001 -> RES=0x00000100 COUT=0 ZERO=0, DONE at accept+5
//  ADD M=0 CIN=0 A=0xFFFFFFFF B=0x00000001 -> RES=0x00000000 COUT=1 ZERO=1
//  SUB M=0 CIN=0 A=0x00000100 B=1 -> RES=0x000000FF COUT=0; A=0 B=1 -> RES=0xFFFFFFFF COUT=1
//  OP=1001 M=1 A=0xF0F0F0F0 B=0xFF00FF00 -> RES=0xF00FF00F (XNOR) COUT=0
//  REQ pulsed during RUN -> ignored; REQ held in FIN -> next op starts, DONE again 5 cycles later
//  RST_N=0 at beat 2 -> next cycle BUSY=DONE=0, RES=0, ALU_*=0, no DONE; following ADD correct

Source files
------------

// File: rtl/alu_seq_pkg.sv
// Shared types and constants for the 32-bit ALU slice sequencer.
package alu_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_t;

  localparam int SLICE_W = 8;

  localparam logic [3:0] OP_ADD = 4'b1001;
  localparam logic [3:0] OP_SUB = 4'b0110;

endpackage

// File: rtl/alu_seq_shreg.sv
// Operand register: parallel load on accept, then shifts right one slice per
// beat so the current byte is always presented at the bottom.
module alu_seq_shreg
  import alu_seq_pkg::*;
#(
  parameter int W = 32
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_load,
  input  logic               i_shift,
  input  logic [W-1:0]       i_din,
  output logic [SLICE_W-1:0] o_byte
);

  logic [W-1:0] r_data;

  // load wins over shift; the two are never requested together
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_data <= '0;
    end else if (i_load) begin
      r_data <= i_din;
    end else if (i_shift) begin
      r_data <= r_data >> SLICE_W;
    end
  end

  assign o_byte = r_data[SLICE_W-1:0];

endmodule

// File: rtl/alu32_seq_ctrl.sv
// Runs a 32-bit ALU operation as NBEATS byte beats through one external
// 8-bit 74181-style slice, chaining carry/borrow LSB first.
//
//  state | meaning
//  IDLE  | slice quiescent, waiting for a request
//  RUN   | beat r_beat in progress, slice driven with the current byte
//  FIN   | DONE pulse; result/flags valid, a new request is accepted here
module alu32_seq_ctrl
  import alu_seq_pkg::*;
#(
  parameter int NBEATS = 4
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic                      i_req,
  input  logic [3:0]                i_op,
  input  logic                      i_mode,
  input  logic                      i_cin,
  input  logic [SLICE_W*NBEATS-1:0] i_opa,
  input  logic [SLICE_W*NBEATS-1:0] i_opb,
  output logic                      o_busy,
  output logic                      o_done,
  output logic [SLICE_W*NBEATS-1:0] o_res,
  output logic                      o_cout,
  output logic                      o_zero,
  output logic [3:0]                o_alu_s,
  output logic                      o_alu_m,
  output logic                      o_alu_cn,
  output logic [SLICE_W-1:0]        o_alu_a,
  output logic [SLICE_W-1:0]        o_alu_b,
  input  logic [SLICE_W-1:0]        i_alu_f,
  input  logic                      i_alu_co
);

  localparam int W      = SLICE_W * NBEATS;
  localparam int BEAT_W = (NBEATS > 1) ? $clog2(NBEATS) : 1;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(NBEATS - 1);

  state_t              r_state;
  state_t              w_state_nxt;
  logic [BEAT_W-1:0]   r_beat;
  logic [3:0]          r_op;
  logic                r_mode;
  logic                r_cin;
  logic                r_carry;
  logic [W-1:0]        r_res;
  logic                r_cout;
  logic                r_zero;
  logic [W-1:0]        w_res_nxt;
  logic [SLICE_W-1:0]  w_byte_a;
  logic [SLICE_W-1:0]  w_byte_b;
  logic                w_accept;
  logic                w_run;
  logic                w_last;

  assign w_run    = (r_state == RUN);
  assign w_accept = i_req && ((r_state == IDLE) || (r_state == FIN));
  assign w_last   = w_run && (r_beat == LAST_BEAT);

  alu_seq_shreg #(.W(W)) u_shreg_a (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_load  (w_accept),
    .i_shift (w_run),
    .i_din   (i_opa),
    .o_byte  (w_byte_a)
  );

  alu_seq_shreg #(.W(W)) u_shreg_b (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_load  (w_accept),
    .i_shift (w_run),
    .i_din   (i_opb),
    .o_byte  (w_byte_b)
  );

  // state register
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // next state and slice/handshake outputs; slice is only driven in RUN
  always_comb begin
    w_state_nxt = r_state;
    o_busy      = 1'b0;
    o_done      = 1'b0;
    o_alu_s     = '0;
    o_alu_m     = 1'b0;
    o_alu_cn    = 1'b0;
    o_alu_a     = '0;
    o_alu_b     = '0;
    unique case (r_state)
      IDLE: begin
        if (w_accept) w_state_nxt = RUN;
      end
      RUN: begin
        o_busy   = 1'b1;
        o_alu_s  = r_op;
        o_alu_m  = r_mode;
        // logic ops ignore the chain, so CN stays at the latched CIN
        o_alu_cn = (r_mode || (r_beat == '0)) ? r_cin : r_carry;
        o_alu_a  = w_byte_a;
        o_alu_b  = w_byte_b;
        if (w_last) w_state_nxt = FIN;
      end
      FIN: begin
        o_done      = 1'b1;
        w_state_nxt = w_accept ? RUN : IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // result with the current beat's byte merged in
  always_comb begin
    w_res_nxt = r_res;
    w_res_nxt[r_beat*SLICE_W +: SLICE_W] = i_alu_f;
  end

  // operation latch, beat counter, result bytes and flags
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_op    <= '0;
      r_mode  <= 1'b0;
      r_cin   <= 1'b0;
      r_beat  <= '0;
      r_carry <= 1'b0;
      r_res   <= '0;
      r_cout  <= 1'b0;
      r_zero  <= 1'b0;
    end else if (w_accept) begin
      r_op   <= i_op;
      r_mode <= i_mode;
      r_cin  <= i_cin;
      r_beat <= '0;
    end else if (w_run) begin
      r_beat  <= r_beat + 1'b1;
      r_res   <= w_res_nxt;
      r_carry <= i_alu_co;
      if (w_last) begin
        r_cout <= r_mode ? 1'b0 : i_alu_co;
        r_zero <= (w_res_nxt == '0);
      end
    end
  end

  assign o_res  = r_res;
  assign o_cout = r_cout;
  assign o_zero = r_zero;

endmodule
